fp_div_result_buffer: RTL and testbench



---
 rtl/fp_div_pkg.sv | 24 ++
 rtl/fp_sync_fifo.sv | 70 +++++++
 rtl/fp_div_result_buffer.sv | 74 +++++++
 tb/tb_fp_div_result_buffer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// Shared constants for the floating-point divider status word.
// Index constants name each bit of the 8-bit divider status.
package fp_div_pkg;

    localparam int unsigned STATUS_W       = 8;
    localparam int unsigned STATUS_ZERO    = 0;
    localparam int unsigned STATUS_INF     = 1;
    localparam int unsigned STATUS_INVALID = 2;
    localparam int unsigned STATUS_TINY    = 3;
    localparam int unsigned STATUS_HUGE    = 4;
    localparam int unsigned STATUS_INEXACT = 5;
    localparam int unsigned STATUS_RSVD    = 6;
    localparam int unsigned STATUS_DIVZ    = 7;

    localparam logic [STATUS_W-1:0] STATUS_RSVD_MASK = 8'hBF;

    typedef logic [STATUS_W-1:0] status_t;

    // The reserved bit is never allowed to reach the queue or the sticky flags.
    function automatic status_t mask_status(input status_t s);
        return s & STATUS_RSVD_MASK;
    endfunction

endpackage

// File: rtl/fp_sync_fifo.sv
// Synchronous FIFO with a separate occupancy count and no empty bypass.
// The head entry is read from storage at the read pointer.
module fp_sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4,
    localparam int unsigned CntW = $clog2(Depth + 1),
    localparam int unsigned PtrW = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [Width-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [Width-1:0] pop_data,
    output logic [CntW-1:0]  count
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push, pop;

    // Handshake depends only on the registered count, never on pop_ready.
    assign push_ready = (count_q != CntW'(Depth));
    assign pop_valid  = (count_q != '0);
    assign push       = push_valid && push_ready;
    assign pop        = pop_valid && pop_ready;
    assign pop_data   = mem_q[rd_ptr_q];
    assign count      = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fp_div_result_buffer.sv
// Result buffer behind the combinational FP divider: FIFO plus optional sticky flags.
// Define FP_DIV_STICKY_FLAGS_EN to build the sticky exception register.
module fp_div_result_buffer
    import fp_div_pkg::*;
#(
    parameter int unsigned sig_width = 23,
    parameter int unsigned exp_width = 8,
    parameter int unsigned depth     = 4,
    localparam int unsigned isize    = sig_width + exp_width + 1,
    localparam int unsigned cnt_w    = $clog2(depth + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [isize-1:0] z_in,
    input  logic [7:0]       status_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [isize-1:0] z_out,
    output logic [7:0]       status_out,
    output logic [cnt_w-1:0] count,
    input  logic             sticky_clr,
    output logic [7:0]       sticky_flags
);

    status_t status_masked;
    logic    push;

    assign status_masked = mask_status(status_in);
    assign push          = in_valid && in_ready;

    fp_sync_fifo #(
        .Width(isize + STATUS_W),
        .Depth(depth)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_valid(in_valid),
        .push_ready(in_ready),
        .push_data ({status_masked, z_in}),
        .pop_valid (out_valid),
        .pop_ready (out_ready),
        .pop_data  ({status_out, z_out}),
        .count     (count)
    );

`ifdef FP_DIV_STICKY_FLAGS_EN
    status_t sticky_q, sticky_d;

    // Clear is applied before the OR so a simultaneous push survives the clear.
    always_comb begin
        sticky_d = sticky_clr ? '0 : sticky_q;
        if (push) begin
            sticky_d = sticky_d | status_masked;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_flags = sticky_q;
`else
    logic unused_sticky;
    assign unused_sticky = sticky_clr ^ push;
    assign sticky_flags  = '0;
`endif

endmodule

// File: tb/tb_fp_div_result_buffer.sv
// Directed self-checking bench for fp_div_result_buffer (default 32-bit word, depth 4).
module tb_fp_div_result_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] z_in;
    logic [7:0]  status_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] z_out;
    logic [7:0]  status_out;
    logic [2:0]  count;
    logic        sticky_clr;
    logic [7:0]  sticky_flags;

    int checks   = 0;
    int failures = 0;

    logic [31:0] vals [4];

    fp_div_result_buffer u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .z_in        (z_in),
        .status_in   (status_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .z_out       (z_out),
        .status_out  (status_out),
        .count       (count),
        .sticky_clr  (sticky_clr),
        .sticky_flags(sticky_flags)
    );

    always #5 clk = ~clk;

    // Expected sticky value depends on whether the feature is built in.
    function automatic logic [7:0] sx(input logic [7:0] v);
`ifdef FP_DIV_STICKY_FLAGS_EN
        return v;
`else
        return 8'h00 & v;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vals[0] = 32'h3F800000;
        vals[1] = 32'h40000000;
        vals[2] = 32'h40400000;
        vals[3] = 32'h40800000;

        rst = 1'b1; in_valid = 1'b0; z_in = '0; status_in = '0;
        out_ready = 1'b0; sticky_clr = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sticky", 32'(sticky_flags), 32'h00);
        check("rst_z_out", z_out, 32'h0);
        check("rst_status_out", 32'(status_out), 32'h00);

        // Single push with consumer ready.
        in_valid = 1'b1; z_in = 32'h3F800000; status_in = 8'h00; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("single_out_valid", 32'(out_valid), 32'd1);
        check("single_z_out", z_out, 32'h3F800000);
        check("single_count1", 32'(count), 32'd1);
        step();
        check("single_count0", 32'(count), 32'd0);
        check("single_empty", 32'(out_valid), 32'd0);

        // Fill to full, then a rejected fifth push.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; z_in = vals[i];
            step();
        end
        check("full_count", 32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        z_in = 32'hDEADBEEF;
        step();
        in_valid = 1'b0;
        check("full_5th_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", 32'(out_valid), 32'd1);
            check("drain_z", z_out, vals[i]);
            step();
        end
        check("drain_empty", 32'(count), 32'd0);

        // Full with push and pop offered together: only the pop happens.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; z_in = vals[i];
            step();
        end
        in_valid = 1'b1; z_in = 32'h11111111; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("fullpp_count", 32'(count), 32'd3);
        for (int i = 1; i < 4; i++) begin
            check("fullpp_z", z_out, vals[i]);
            step();
        end
        check("fullpp_empty", 32'(count), 32'd0);
        check("fullpp_no_ready", 32'(out_valid), 32'd0);

        // Sticky accumulation, clear with simultaneous push, reserved-bit masking.
        out_ready = 1'b1;
        in_valid = 1'b1; z_in = 32'h7F800000; status_in = 8'h82;
        step();
        check("stk_z_a", z_out, 32'h7F800000);
        check("stk_st_a", 32'(status_out), 32'h82);
        check("stk_a", 32'(sticky_flags), 32'(sx(8'h82)));
        z_in = 32'h00000000; status_in = 8'h29;
        step();
        check("stk_pp_count", 32'(count), 32'd1);
        check("stk_st_b", 32'(status_out), 32'h29);
        check("stk_ab", 32'(sticky_flags), 32'(sx(8'hAB)));
        z_in = 32'h3F800000; status_in = 8'h41; sticky_clr = 1'b1;
        step();
        check("stk_st_masked", 32'(status_out), 32'h01);
        check("stk_clr_push", 32'(sticky_flags), 32'(sx(8'h01)));
        in_valid = 1'b0; sticky_clr = 1'b0;
        step();
        check("stk_pop_keeps", 32'(sticky_flags), 32'(sx(8'h01)));
        check("stk_empty", 32'(count), 32'd0);
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        check("stk_clr_only", 32'(sticky_flags), 32'h00);

        // Reset mid-operation with input still offered on the reset edge.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; z_in = vals[i]; status_in = 8'h04;
            step();
        end
        check("mid_count3", 32'(count), 32'd3);
        check("mid_sticky", 32'(sticky_flags), 32'(sx(8'h04)));
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sticky", 32'(sticky_flags), 32'h00);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        step();
        check("mid_rst_idle", 32'(count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
